// File: rtl/tile_ram_arbiter.sv
// Tile RAM arbiter: renderer owns RAM while busy plus a guard window;
// CPU writes drain from a FIFO in free cycles, CPU reads are coherent.
module tile_ram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int GUARD      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic              cpu_full,
    output logic              cpu_overflow,
    output logic              cpu_rbusy,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_busy,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(GUARD + 2);

    logic [ADDR_W-1:0] r_fa [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fd [FIFO_DEPTH];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              r_full;
    logic              r_ovf;
    logic [GW-1:0]     r_guard;
    logic              r_rpend;
    logic              r_issued;
    logic              r_rvalid;
    logic [ADDR_W-1:0] r_raddr;
    logic [DATA_W-1:0] r_rdata;

    logic w_grant;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_issue;
    logic w_accept;

    assign w_grant  = !vid_busy && (r_guard == '0);
    assign w_empty  = (r_cnt == '0);
    assign w_push   = cpu_we && !r_full;
    assign w_pop    = w_grant && !w_empty;
    assign w_issue  = w_grant && w_empty && r_rpend && !r_issued;
    assign w_accept = cpu_re && !r_rpend;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop)
            w_cnt_nxt = r_cnt + CW'(1);
        else if (!w_push && w_pop)
            w_cnt_nxt = r_cnt - CW'(1);
    end

    // FIFO storage carries no reset; validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fa[r_wp] <= cpu_addr;
            r_fd[r_wp] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_full <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push)
                r_wp <= r_wp + PW'(1);
            if (w_pop)
                r_rp <= r_rp + PW'(1);
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == CW'(FIFO_DEPTH));
            if (cpu_we && r_full)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_guard <= '0;
        else if (vid_busy)
            r_guard <= GW'(GUARD);
        else if (r_guard != '0)
            r_guard <= r_guard - GW'(1);
    end

    // Data is captured the cycle after issue regardless of grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rpend  <= 1'b0;
            r_issued <= 1'b0;
            r_rvalid <= 1'b0;
            r_raddr  <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= 1'b0;
            if (w_accept) begin
                r_rpend <= 1'b1;
                r_raddr <= cpu_addr;
            end
            if (w_issue)
                r_issued <= 1'b1;
            if (r_issued) begin
                r_issued <= 1'b0;
                r_rpend  <= 1'b0;
                r_rvalid <= 1'b1;
                r_rdata  <= ram_dout;
            end
        end
    end

    always_comb begin
        ram_addr = vid_addr;
        ram_din  = r_fd[r_rp];
        ram_we   = 1'b0;
        if (w_pop) begin
            ram_addr = r_fa[r_rp];
            ram_we   = !reset;
        end else if (w_issue) begin
            ram_addr = r_raddr;
        end
    end

    assign cpu_full     = r_full;
    assign cpu_overflow = r_ovf;
    assign cpu_rbusy    = r_rpend;
    assign cpu_rvalid   = r_rvalid;
    assign cpu_rdata    = r_rdata;
    assign vid_rdata    = ram_dout;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Bench for tile_ram_arbiter: sync RAM model, write/read scoreboards
// checked by a negedge monitor, plus directed timing checks.
module tb_tile_ram_arbiter;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic        cpu_full;
    logic        cpu_overflow;
    logic        cpu_rbusy;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        vid_busy;
    logic [15:0] vid_addr;
    logic [15:0] vid_rdata;
    logic [15:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [15:0] ram_dout;

    logic [15:0] mem [0:65535];

    wr_t         wq[$];
    logic [15:0] rq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rv_cnt  = 0;

    tile_ram_arbiter #(
        .ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(8), .GUARD(2)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_full(cpu_full), .cpu_overflow(cpu_overflow),
        .cpu_rbusy(cpu_rbusy), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .vid_busy(vid_busy), .vid_addr(vid_addr),
        .vid_rdata(vid_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM_sync model: write-first not required, read returns old data.
    always @(posedge clk) begin
        if (ram_we === 1'b1)
            mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (wq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h",
                         ram_addr, ram_din);
            end else begin
                wr_t e;
                e = wq.pop_front();
                check("wr_addr", {16'h0, ram_addr}, {16'h0, e.a});
                check("wr_data", {16'h0, ram_din}, {16'h0, e.d});
            end
        end
        if (cpu_rvalid === 1'b1) begin
            rv_cnt++;
            if (rq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rvalid: rdata %h", cpu_rdata);
            end else begin
                check("rdata", {16'h0, cpu_rdata}, {16'h0, rq.pop_front()});
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++)
            mem[i] = 16'(i) ^ 16'h5a5a;
        reset     = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_we    = 1'b0;
        cpu_re    = 1'b0;
        vid_busy  = 1'b0;
        vid_addr  = 16'h0000;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_full", {31'h0, cpu_full}, 32'h0);
        check("rst_ovf", {31'h0, cpu_overflow}, 32'h0);
        check("rst_rbusy", {31'h0, cpu_rbusy}, 32'h0);
        check("rst_rvalid", {31'h0, cpu_rvalid}, 32'h0);
        check("rst_rdata", {16'h0, cpu_rdata}, 32'h0);
        check("rst_we", {31'h0, ram_we}, 32'h0);

        // 1: three back-to-back writes while idle
        tick();
        cpu_we = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 16'hfa1b;
        wq.push_back('{16'h0000, 16'hfa1b});
        @(negedge clk);
        check("t1_we_c0", {31'h0, ram_we}, 32'h0);
        tick();
        cpu_addr = 16'h0001; cpu_wdata = 16'hfc18;
        wq.push_back('{16'h0001, 16'hfc18});
        @(negedge clk);
        check("t1_we_c1", {31'h0, ram_we}, 32'h1);
        tick();
        cpu_addr = 16'h001f; cpu_wdata = 16'hfb1a;
        wq.push_back('{16'h001f, 16'hfb1a});
        @(negedge clk);
        check("t1_we_c2", {31'h0, ram_we}, 32'h1);
        tick();
        cpu_we = 1'b0;
        @(negedge clk);
        check("t1_we_c3", {31'h0, ram_we}, 32'h1);
        tick();
        @(negedge clk);
        check("t1_we_c4", {31'h0, ram_we}, 32'h0);

        // 2: fill while renderer busy, overflow, then guard window
        tick();
        vid_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cpu_we    = 1'b1;
            cpu_addr  = 16'h0100 + 16'(i);
            cpu_wdata = 16'h1000 + 16'(i);
            vid_addr  = 16'h2000 + 16'(i);
            if (i < 8)
                wq.push_back('{16'h0100 + 16'(i), 16'h1000 + 16'(i)});
            @(negedge clk);
            check("t2_full", {31'h0, cpu_full}, {31'h0, i == 8});
            check("t2_we0", {31'h0, ram_we}, 32'h0);
            check("t2_vaddr", {16'h0, ram_addr}, {16'h0, vid_addr});
            tick();
        end
        cpu_we   = 1'b0;
        vid_addr = 16'h3333;
        @(negedge clk);
        check("t2_ovf", {31'h0, cpu_overflow}, 32'h1);
        check("t2_full_hold", {31'h0, cpu_full}, 32'h1);
        tick();
        vid_busy = 1'b0;
        @(negedge clk);
        check("t2_guard0", {31'h0, ram_we}, 32'h0);
        tick();
        @(negedge clk);
        check("t2_guard1", {31'h0, ram_we}, 32'h0);
        tick();
        @(negedge clk);
        check("t2_first_we", {31'h0, ram_we}, 32'h1);
        repeat (10) tick();
        check("t2_drained", wq.size(), 32'd0);

        // 3: write and read same address in one cycle
        cpu_we = 1'b1; cpu_re = 1'b1;
        cpu_addr = 16'h7e05; cpu_wdata = 16'habcd;
        wq.push_back('{16'h7e05, 16'habcd});
        rq.push_back(16'habcd);
        tick();
        cpu_we = 1'b0; cpu_re = 1'b0;
        for (int i = 0; i < 10 && rq.size() != 0; i++)
            tick();
        check("t3_read_done", rq.size(), 32'd0);

        // 4: read issued in last granted cycle, renderer takes over next
        tick();
        cpu_re = 1'b1; cpu_addr = 16'h0042;
        rq.push_back(16'h5a18);
        tick();
        cpu_re = 1'b0;
        @(negedge clk);
        check("t4_issue_addr", {16'h0, ram_addr}, 32'h0042);
        tick();
        vid_busy = 1'b1; vid_addr = 16'h0077;
        tick();
        @(negedge clk);
        check("t4_rvalid", {31'h0, cpu_rvalid}, 32'h1);
        check("t4_vid_rdata", {16'h0, vid_rdata}, 32'h5a2d);
        tick();
        vid_busy = 1'b0;
        repeat (3) tick();

        // 5: reset with writes queued and a read pending
        vid_busy = 1'b1; vid_addr = 16'h0500;
        for (int i = 0; i < 4; i++) begin
            cpu_we    = 1'b1;
            cpu_addr  = 16'h0600 + 16'(i);
            cpu_wdata = 16'hdead;
            cpu_re    = (i == 3);
            tick();
        end
        cpu_we = 1'b0; cpu_re = 1'b0;
        @(negedge clk);
        check("t5_rbusy_pre", {31'h0, cpu_rbusy}, 32'h1);
        tick();
        reset = 1'b1; vid_busy = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t5_full", {31'h0, cpu_full}, 32'h0);
        check("t5_ovf", {31'h0, cpu_overflow}, 32'h0);
        check("t5_rbusy", {31'h0, cpu_rbusy}, 32'h0);
        check("t5_rvalid", {31'h0, cpu_rvalid}, 32'h0);
        check("t5_rdata", {16'h0, cpu_rdata}, 32'h0);
        check("t5_we", {31'h0, ram_we}, 32'h0);
        repeat (8) tick();

        // 6: second read while busy is ignored
        rv_cnt = 0;
        cpu_re = 1'b1; cpu_addr = 16'h0100;
        rq.push_back(16'h1000);
        tick();
        cpu_addr = 16'h0101;
        @(negedge clk);
        check("t6_rbusy", {31'h0, cpu_rbusy}, 32'h1);
        tick();
        cpu_re = 1'b0;
        repeat (10) tick();
        check("t6_one_rvalid", rv_cnt, 32'd1);

        check("end_wq_empty", wq.size(), 32'd0);
        check("end_rq_empty", rq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
